// File: rtl/dram_reader_pkg.sv
// Shared types, AXI constants and 4 KB burst-split helper for the DRAM burst reader.
package dram_reader_pkg;

    typedef enum logic [2:0] {StIdle, StAr1, StR1, StAr2, StR2} state_e;

    localparam logic [2:0]  AXI_SIZE_16B     = 3'b100;
    localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam int unsigned BEATS_PER_4K     = 256;
    localparam int unsigned SPLIT_ADDR_WIDTH = 39;

    typedef struct packed {
        logic [7:0]                  arlen1;
        logic                        split;
        logic [SPLIT_ADDR_WIDTH-1:0] addr2;
        logic [7:0]                  arlen2;
    } split_t;

    // total is the beat count (1..256); addr must already be 16 B aligned.
    function automatic split_t split_burst(input logic [SPLIT_ADDR_WIDTH-1:0] addr,
                                           input logic [8:0]                  total);
        split_t     r;
        logic [8:0] room;
        room    = 9'(BEATS_PER_4K) - {1'b0, addr[11:4]};
        // Next 4 KB page start, modulo the address width.
        r.addr2 = (addr | SPLIT_ADDR_WIDTH'(12'hFFF)) + SPLIT_ADDR_WIDTH'(1);
        if (total <= room) begin
            r.split  = 1'b0;
            r.arlen1 = 8'(total - 9'd1);
            r.arlen2 = 8'h00;
        end else begin
            r.split  = 1'b1;
            r.arlen1 = 8'(room - 9'd1);
            r.arlen2 = 8'(total - room - 9'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/dram_burst_reader_if.sv
// AXI4 read address/data channel bundle between the burst reader and the HP port.
interface dram_burst_reader_if #(
    parameter int unsigned DRAM_ADDR_WIDTH = 39,
    parameter int unsigned DRAM_DATA_WIDTH = 128
);
    logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]                 m_axi_arlen;
    logic [2:0]                 m_axi_arsize;
    logic [1:0]                 m_axi_arburst;
    logic                       m_axi_arvalid;
    logic                       m_axi_arready;
    logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]                 m_axi_rresp;
    logic                       m_axi_rlast;
    logic                       m_axi_rvalid;
    logic                       m_axi_rready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/dram_burst_reader.sv
// DRAM read engine: one request becomes one or two AXI4 INCR bursts split at 4 KB,
// with each returned beat forwarded as a registered one-cycle strobe.
module dram_burst_reader
    import dram_reader_pkg::*;
#(
    parameter int unsigned DRAM_ADDR_WIDTH = SPLIT_ADDR_WIDTH,
    parameter int unsigned DRAM_DATA_WIDTH = 128
) (
    input  logic                       clk_pixel,
    input  logic                       dram_reader_reset,
    input  logic                       dram_read_en,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
    input  logic [7:0]                 dram_read_len,
    output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
    output logic                       dram_read_data_valid,
    output logic                       dram_read_busy,
    output logic                       dram_read_error,
    output logic                       dram_read_overrun,
    dram_burst_reader_if.master        axi
);

    state_e                     state_q, state_d;
    logic [DRAM_ADDR_WIDTH-1:0] araddr_q, araddr_d, addr2_q, addr2_d;
    logic [7:0]                 arlen_q, arlen_d, arlen2_q, arlen2_d;
    logic                       split_q, split_d;
    logic [8:0]                 cnt_q, cnt_d;
    logic [DRAM_DATA_WIDTH-1:0] data_q, data_d;
    logic                       valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;

    logic [DRAM_ADDR_WIDTH-1:0] req_addr;
    logic [8:0]                 req_total;
    split_t                     sp;
    logic                       in_burst, beat, last_cnt, burst_end;

    assign req_addr  = dram_read_addr & ~DRAM_ADDR_WIDTH'(4'hF);
    assign req_total = {1'b0, dram_read_len} + 9'd1;
    assign sp        = split_burst(req_addr, req_total);

    // Beats outside R1/R2 are strays: handshaken but dropped.
    assign in_burst  = (state_q == StR1) || (state_q == StR2);
    assign beat      = axi.m_axi_rvalid & axi.m_axi_rready & in_burst;
    assign last_cnt  = (cnt_q == 9'd1);
    assign burst_end = beat & (last_cnt | axi.m_axi_rlast);

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        addr2_d  = addr2_q;
        arlen2_d = arlen2_q;
        split_d  = split_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        valid_d  = beat;
        err_d    = err_q | (beat & ((axi.m_axi_rresp != AXI_RESP_OKAY) |
                                    (axi.m_axi_rlast != last_cnt)));
        ovr_d    = ovr_q | (dram_read_en & (state_q != StIdle));

        if (beat) begin
            data_d = axi.m_axi_rdata;
            cnt_d  = cnt_q - 9'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (dram_read_en) begin
                    araddr_d = req_addr;
                    arlen_d  = sp.arlen1;
                    split_d  = sp.split;
                    addr2_d  = sp.addr2;
                    arlen2_d = sp.arlen2;
                    state_d  = StAr1;
                end
            end
            StAr1, StAr2: begin
                if (axi.m_axi_arready) begin
                    cnt_d   = {1'b0, arlen_q} + 9'd1;
                    state_d = (state_q == StAr1) ? StR1 : StR2;
                end
            end
            StR1: begin
                if (burst_end) begin
                    if (split_q) begin
                        araddr_d = addr2_q;
                        arlen_d  = arlen2_q;
                        state_d  = StAr2;
                    end else begin
                        state_d  = StIdle;
                    end
                end
            end
            StR2: begin
                if (burst_end) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (dram_reader_reset) begin
            state_q  <= StIdle;
            araddr_q <= '0;
            arlen_q  <= '0;
            addr2_q  <= '0;
            arlen2_q <= '0;
            split_q  <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            addr2_q  <= addr2_d;
            arlen2_q <= arlen2_d;
            split_q  <= split_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign dram_read_data       = data_q;
    assign dram_read_data_valid = valid_q;
    assign dram_read_busy       = (state_q != StIdle);
    assign dram_read_error      = err_q;
    assign dram_read_overrun    = ovr_q;

    assign axi.m_axi_araddr  = araddr_q;
    assign axi.m_axi_arlen   = arlen_q;
    assign axi.m_axi_arsize  = AXI_SIZE_16B;
    assign axi.m_axi_arburst = AXI_BURST_INCR;
    assign axi.m_axi_arvalid = (state_q == StAr1) || (state_q == StAr2);
    assign axi.m_axi_rready  = ~dram_reader_reset;

endmodule

// File: tb/tb_dram_burst_reader.sv
// Directed bench for dram_burst_reader with a queue scoreboard on returned beats.
module tb_dram_burst_reader;

    localparam int unsigned AW = 39;
    localparam int unsigned DW = 128;

    logic          clk_pixel = 1'b0;
    logic          dram_reader_reset = 1'b1;
    logic          dram_read_en = 1'b0;
    logic [AW-1:0] dram_read_addr = '0;
    logic [7:0]    dram_read_len = '0;
    logic [DW-1:0] dram_read_data;
    logic          dram_read_data_valid, dram_read_busy, dram_read_error, dram_read_overrun;

    dram_burst_reader_if #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) axi ();

    dram_burst_reader #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) dut (
        .clk_pixel            (clk_pixel),
        .dram_reader_reset    (dram_reader_reset),
        .dram_read_en         (dram_read_en),
        .dram_read_addr       (dram_read_addr),
        .dram_read_len        (dram_read_len),
        .dram_read_data       (dram_read_data),
        .dram_read_data_valid (dram_read_data_valid),
        .dram_read_busy       (dram_read_busy),
        .dram_read_error      (dram_read_error),
        .dram_read_overrun    (dram_read_overrun),
        .axi                  (axi.master)
    );

    always #5 clk_pixel = ~clk_pixel;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic          fwd_flag = 1'b0;
    logic          pend     = 1'b0;
    logic          mon_en   = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    // Every cycle: strobe must follow a forwarded handshake by exactly one cycle.
    always @(negedge clk_pixel) begin
        if (mon_en) begin
            check("valid_timing", DW'(dram_read_data_valid), DW'(pend));
            if (dram_read_data_valid === 1'b1) begin
                check("scoreboard_nonempty", DW'(exp_q.size() > 0), DW'(1'b1));
                if (exp_q.size() > 0) check("beat_data", dram_read_data, exp_q.pop_front());
            end
            pend = axi.m_axi_rvalid & fwd_flag & ~dram_reader_reset;
        end
    end

    task automatic request(input logic [AW-1:0] addr, input logic [7:0] len);
        dram_read_en   = 1'b1;
        dram_read_addr = addr;
        dram_read_len  = len;
        tick();
        dram_read_en   = 1'b0;
        check("busy_rise", DW'(dram_read_busy), DW'(1'b1));
        check("arvalid_rise", DW'(axi.m_axi_arvalid), DW'(1'b1));
    endtask

    task automatic ar_accept(input string tag, input logic [AW-1:0] exp_addr,
                             input logic [7:0] exp_len, input int stall);
        int k = 0;
        while (axi.m_axi_arvalid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_arvalid"}, DW'(axi.m_axi_arvalid), DW'(1'b1));
        for (int i = 0; i < stall; i++) begin
            check({tag, "_hold_valid"}, DW'(axi.m_axi_arvalid), DW'(1'b1));
            check({tag, "_hold_addr"}, DW'(axi.m_axi_araddr), DW'(exp_addr));
            check({tag, "_hold_len"}, DW'(axi.m_axi_arlen), DW'(exp_len));
            tick();
        end
        check({tag, "_araddr"}, DW'(axi.m_axi_araddr), DW'(exp_addr));
        check({tag, "_arlen"}, DW'(axi.m_axi_arlen), DW'(exp_len));
        check({tag, "_arsize"}, DW'(axi.m_axi_arsize), DW'(3'b100));
        check({tag, "_arburst"}, DW'(axi.m_axi_arburst), DW'(2'b01));
        axi.m_axi_arready = 1'b1;
        tick();
        axi.m_axi_arready = 1'b0;
        check({tag, "_arvalid_drop"}, DW'(axi.m_axi_arvalid), DW'(1'b0));
    endtask

    // rlast on index last_idx (-1: never); rresp SLVERR on index bad_idx.
    task automatic send_beats(input int n, input logic [63:0] base, input int bad_idx,
                              input int last_idx, input logic fwd);
        for (int i = 0; i < n; i++) begin
            axi.m_axi_rvalid = 1'b1;
            axi.m_axi_rdata  = {base, 64'(i) ^ 64'h0123_4567_89AB_CDEF};
            axi.m_axi_rresp  = (i == bad_idx) ? 2'b10 : 2'b00;
            axi.m_axi_rlast  = (i == last_idx);
            fwd_flag         = fwd;
            if (fwd) exp_q.push_back(axi.m_axi_rdata);
            tick();
        end
        axi.m_axi_rvalid = 1'b0;
        axi.m_axi_rlast  = 1'b0;
        axi.m_axi_rresp  = 2'b00;
        fwd_flag         = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_data"}, dram_read_data, '0);
        check({tag, "_valid"}, DW'(dram_read_data_valid), '0);
        check({tag, "_busy"}, DW'(dram_read_busy), '0);
        check({tag, "_error"}, DW'(dram_read_error), '0);
        check({tag, "_overrun"}, DW'(dram_read_overrun), '0);
        check({tag, "_arvalid"}, DW'(axi.m_axi_arvalid), '0);
        check({tag, "_araddr"}, DW'(axi.m_axi_araddr), '0);
        check({tag, "_arlen"}, DW'(axi.m_axi_arlen), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rdata   = '0;
        axi.m_axi_rresp   = 2'b00;
        axi.m_axi_rlast   = 1'b0;

        // Reset
        tick();
        tick();
        check("rready_in_reset", DW'(axi.m_axi_rready), DW'(1'b0));
        check_reset_state("reset");
        dram_reader_reset = 1'b0;
        #1;
        check("rready_after_reset", DW'(axi.m_axi_rready), DW'(1'b1));
        mon_en = 1'b1;
        tick();

        // Single 16-beat burst with addr low bits ignored
        request(39'h0000_1007, 8'd15);
        ar_accept("single", 39'h0000_1000, 8'd15, 0);
        send_beats(15, 64'h1111, -1, -1, 1'b1);
        check("single_busy_mid", DW'(dram_read_busy), DW'(1'b1));
        send_beats(1, 64'h1112, -1, 0, 1'b1);
        check("single_busy_fall", DW'(dram_read_busy), DW'(1'b0));
        check("single_last_valid", DW'(dram_read_data_valid), DW'(1'b1));
        check("single_no_error", DW'(dram_read_error), DW'(1'b0));

        // 4 KB boundary split, then back-to-back request the cycle busy falls
        request(39'h0000_0FC0, 8'd7);
        ar_accept("split1", 39'h0000_0FC0, 8'd3, 0);
        send_beats(4, 64'h2222, -1, 3, 1'b1);
        check("split_busy_between", DW'(dram_read_busy), DW'(1'b1));
        check("split_ar2_rise", DW'(axi.m_axi_arvalid), DW'(1'b1));
        ar_accept("split2", 39'h0000_1000, 8'd3, 0);
        send_beats(4, 64'h2223, -1, 3, 1'b1);
        check("split_busy_fall", DW'(dram_read_busy), DW'(1'b0));

        // Worst-case split: one beat before the page end, 255 after
        request(39'h0000_5FF0, 8'd255);
        ar_accept("maxsplit1", 39'h0000_5FF0, 8'd0, 0);
        send_beats(1, 64'h3333, -1, 0, 1'b1);
        ar_accept("maxsplit2", 39'h0000_6000, 8'd254, 0);
        send_beats(255, 64'h3334, -1, 254, 1'b1);
        check("maxsplit_busy_fall", DW'(dram_read_busy), DW'(1'b0));

        // Page-aligned 256 beats never split
        request(39'h0000_7000, 8'd255);
        ar_accept("full_page", 39'h0000_7000, 8'd255, 0);
        send_beats(256, 64'h4444, -1, 255, 1'b1);
        check("full_page_busy_fall", DW'(dram_read_busy), DW'(1'b0));

        // Top-of-address-space split wraps to zero
        request(39'h7F_FFFF_FFE0, 8'd2);
        ar_accept("wrap1", 39'h7F_FFFF_FFE0, 8'd1, 0);
        send_beats(2, 64'h4545, -1, 1, 1'b1);
        ar_accept("wrap2", 39'h0, 8'd0, 0);
        send_beats(1, 64'h4546, -1, 0, 1'b1);

        // AR backpressure for 10 cycles
        request(39'h0001_2340, 8'd2);
        ar_accept("backpressure", 39'h0001_2340, 8'd2, 10);
        send_beats(3, 64'h5555, -1, 2, 1'b1);
        check("backpressure_busy_fall", DW'(dram_read_busy), DW'(1'b0));

        // Request while busy is dropped and flagged
        request(39'h0002_0000, 8'd3);
        ar_accept("overrun", 39'h0002_0000, 8'd3, 0);
        send_beats(1, 64'h6666, -1, -1, 1'b1);
        dram_read_en   = 1'b1;
        dram_read_addr = 39'h0003_0000;
        dram_read_len  = 8'd9;
        tick();
        dram_read_en   = 1'b0;
        check("overrun_flag", DW'(dram_read_overrun), DW'(1'b1));
        send_beats(3, 64'h6667, -1, 2, 1'b1);
        check("overrun_busy_fall", DW'(dram_read_busy), DW'(1'b0));
        tick();
        check("overrun_no_ar", DW'(axi.m_axi_arvalid), DW'(1'b0));
        check("overrun_sticky", DW'(dram_read_overrun), DW'(1'b1));

        // SLVERR on beat 3: all beats forwarded, error sticks
        request(39'h0004_0000, 8'd3);
        ar_accept("resp_err", 39'h0004_0000, 8'd3, 0);
        send_beats(2, 64'h7777, -1, -1, 1'b1);
        check("resp_err_clear_before", DW'(dram_read_error), DW'(1'b0));
        send_beats(2, 64'h7778, 0, 1, 1'b1);
        check("resp_err_flag", DW'(dram_read_error), DW'(1'b1));
        check("resp_err_busy_fall", DW'(dram_read_busy), DW'(1'b0));

        // Clear sticky flags, then early rlast on beat 2 of 4
        dram_reader_reset = 1'b1;
        tick();
        dram_reader_reset = 1'b0;
        check("flags_cleared", DW'({dram_read_error, dram_read_overrun}), DW'(2'b00));
        request(39'h0005_0000, 8'd3);
        ar_accept("early_last", 39'h0005_0000, 8'd3, 0);
        send_beats(2, 64'h8888, -1, 1, 1'b1);
        check("early_last_error", DW'(dram_read_error), DW'(1'b1));
        check("early_last_busy_fall", DW'(dram_read_busy), DW'(1'b0));
        tick();
        check("early_last_idle", DW'(axi.m_axi_arvalid), DW'(1'b0));

        // Reset after beat 5 of 16, stray beats, then a clean transfer
        request(39'h0006_0000, 8'd15);
        ar_accept("midreset", 39'h0006_0000, 8'd15, 0);
        send_beats(5, 64'h9999, -1, -1, 1'b1);
        dram_reader_reset = 1'b1;
        tick();
        dram_reader_reset = 1'b0;
        check_reset_state("midreset");
        send_beats(11, 64'h999A, -1, 10, 1'b0);
        check("stray_no_error", DW'(dram_read_error), DW'(1'b0));
        check("stray_idle", DW'(dram_read_busy), DW'(1'b0));
        request(39'h0007_0FE0, 8'd3);
        ar_accept("after_reset1", 39'h0007_0FE0, 8'd1, 0);
        send_beats(2, 64'hAAAA, -1, 1, 1'b1);
        ar_accept("after_reset2", 39'h0007_1000, 8'd1, 0);
        send_beats(2, 64'hAAAB, -1, 1, 1'b1);
        check("after_reset_busy_fall", DW'(dram_read_busy), DW'(1'b0));
        check("after_reset_no_error", DW'(dram_read_error), DW'(1'b0));

        tick();
        tick();
        check("scoreboard_drained", DW'(exp_q.size()), DW'(0));
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_burst_reader.md
# dram_burst_reader

DRAM read engine that serves the image pipeline's DRAM read request interface. It accepts a single-pulse read request (address, beat count) and turns it into one or two AXI4 INCR read bursts, splitting at 4 KB boundaries. It returns each 128-bit beat as a one-cycle `dram_read_data_valid` strobe and holds `dram_read_busy` for the whole transaction. It sits between the image data buffering logic and the PS HP AXI slave port, on the pixel clock domain.

## Interface
- `DRAM_ADDR_WIDTH`, 39, width of the byte address, and of `m_axi_araddr`
- `DRAM_DATA_WIDTH`, 128, beat width; fixed at 128, which gives ARSIZE = 3'b100 (16 B)
- `clk_pixel`  in  1  sole clock
- `dram_reader_reset`  in  1  synchronous, active-high reset
- `dram_read_en`  in  1  one-cycle request strobe; accepted only while `dram_read_busy` = 0
- `dram_read_addr`  in  DRAM_ADDR_WIDTH  byte start address; bits [3:0] are ignored (forced 0)
- `dram_read_len`  in  8  number of beats minus 1 (0..255)
- `dram_read_data`  out  DRAM_DATA_WIDTH  returned beat
- `dram_read_data_valid`  out  1  one-cycle strobe per beat
- `dram_read_busy`  out  1  transaction in progress
- `dram_read_error`  out  1  sticky: RRESP != OKAY, or an RLAST/beat-count mismatch
- `dram_read_overrun`  out  1  sticky: request strobe arrived while busy
- `m_axi_araddr`  out  DRAM_ADDR_WIDTH, `m_axi_arlen` out 8, `m_axi_arsize` out 3 (constant 3'b100), `m_axi_arburst` out 2 (constant 2'b01)
- `m_axi_arvalid`  out  1, `m_axi_arready`  in  1
- `m_axi_rdata`  in  128, `m_axi_rresp`  in  2, `m_axi_rlast`  in  1, `m_axi_rvalid`  in  1, `m_axi_rready`  out  1

## Operation
- Reset values:
  - `dram_read_data` = 0, `dram_read_data_valid` = 0, `dram_read_busy` = 0.
  - Both sticky flags = 0.
  - `m_axi_arvalid` = 0, `m_axi_araddr` = 0, `m_axi_arlen` = 0.
  - `m_axi_rready` = 0 during reset and 1 at all other times.
- States: IDLE, AR1, R1, AR2, R2.
- IDLE:
  - On `dram_read_en`, latch `addr = {dram_read_addr[DRAM_ADDR_WIDTH-1:4], 4'h0}` and `total = dram_read_len + 1` (9 bits).
  - Compute `room = 256 - addr[11:4]` (9 bits, range 1..256).
  - If `total <= room`: burst 1 uses `arlen = total-1`; the transfer is single-burst.
  - Otherwise: burst 1 uses `arlen = room-1`. Burst 2 uses `addr2 = {addr[W-1:12]+1, 12'h0}` and `arlen2 = total-room-1`.
  - Go to AR1.
- AR1 / AR2:
  - `m_axi_arvalid` = 1, with araddr and arlen held stable until `arready`.
  - On the handshake, drop arvalid and go to R1 / R2.
- R1 / R2:
  - Every beat with `rvalid & rready` is forwarded and decrements the beat counter.
  - On the beat where the counter reaches 0: go to AR2 if split (from R1), else to IDLE.
- Error rule: `dram_read_error` sets if `rresp` != 2'b00 on any beat. It also sets if `rlast` disagrees with counter == 0 on any beat.
- Data is forwarded regardless of error. On early `rlast` the burst is treated as ended; on missing `rlast` the burst ends at counter 0.
- Overrun rule: `dram_read_en` while busy is dropped and sets `dram_read_overrun`. The in-flight transaction is unaffected.
- Beats arriving in IDLE (stray, e.g. after a mid-burst reset) are accepted and discarded. They produce no valid strobe and no error.
- Only one outstanding AR at a time. Burst 2's AR is issued only after burst 1's last beat.

## Timing
- Request strobe at cycle N (busy = 0): `dram_read_busy` and `m_axi_arvalid` rise at N+1. The fastest `arready` handshake is at N+1.
- R handshake at cycle M: `dram_read_data` and `dram_read_data_valid` are registered and appear at M+1. Latency is fixed at 1.
- Last beat handshake at M: `dram_read_busy` falls at M+1, the same cycle the last `dram_read_data_valid` is high. A new request is accepted at M+1 at the earliest.
- Split transfer: AR2's arvalid rises the cycle after burst 1's last beat handshake.
- Address arithmetic is modulo 2^DRAM_ADDR_WIDTH. A wrap at the top of the address space needs no special handling.
- `room` = 256 (addr[11:4] = 0) never splits.

## Structure
- Package `dram_reader_pkg` holds:
  - the state enum
  - constants `AXI_SIZE_16B = 3'b100`, `AXI_BURST_INCR = 2'b01`, `AXI_RESP_OKAY = 2'b00`, `BEATS_PER_4K = 256`
  - a pure function `split_burst(addr, total)` returning arlen1, split flag, addr2, arlen2
- No sub-module; the split logic is a package function, and the FSM and counters live in a single module.

## Test plan
- Single burst: addr 0x0000_1000, len 15, `arready` = 1 → one AR with araddr 0x1000 and arlen 15. Sixteen valid strobes follow, each exactly 1 cycle after its R handshake. Busy is high from N+1 and falls with the 16th strobe.
- Boundary split: addr 0x0FC0, len 7 → AR1 with araddr 0x0FC0 and arlen 3, then AR2 with araddr 0x1000 and arlen 3 after beat 4. Eight strobes total, and data order is preserved.
- AR backpressure: `arready` low for 10 cycles → arvalid, araddr and arlen stay stable, with no strobes. The handshake at cycle 11 proceeds normally.
- Request while busy: second `dram_read_en` during R1 → ignored and `dram_read_overrun` = 1. Only the first transaction's beats are returned.
- Errors: rresp 2'b10 on beat 3 → all beats still forwarded and `dram_read_error` latches 1. A separate run with `rlast` on beat 2 of a 4-beat burst → error = 1, FSM returns to IDLE, busy drops.
- Reset mid-burst: reset asserted after beat 5 of 16 → all outputs return to their reset values. The remaining 11 stray beats after reset are discarded with no strobes and no error. A new request then completes correctly.
